// File: rtl/exec_trace_monitor.sv
// exec_trace_monitor
//   Watches a CPU's register-file write-back port and records every
//   architecturally visible write ({pc, rd, data}) into a show-ahead FIFO.
//   Writes to x0 are ignored. The monitor also counts run cycles and
//   terminates the run on a halt (PC stuck for HALT_REPEAT samples) or on
//   a cycle timeout.
//
// Ports
//   clk            : single clock, all state on rising edge
//   start          : synchronous active-low reset (0 = held in reset)
//   pc_i           : CPU program counter, sampled each edge
//   reg_write_i    : register-file write enable
//   rd_i           : destination register index
//   wb_data_i      : write-back data
//   trace_ready_i  : consumer pop request
//   trace_valid_o  : FIFO head entry valid
//   trace_pc_o     : head entry PC
//   trace_rd_o     : head entry destination register
//   trace_data_o   : head entry write-back data
//   count_o        : FIFO occupancy
//   overflow_o     : sticky, a capture was dropped on a full FIFO
//   cycles_o       : RUN cycles elapsed
//   halted_o       : run ended by PC halt detection
//   timeout_o      : run ended by cycle limit
//   done_o         : halted_o | timeout_o
module exec_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 300,
  parameter int HALT_REPEAT = 4
) (
  input  logic                     clk,
  input  logic                     start,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     reg_write_i,
  input  logic [4:0]               rd_i,
  input  logic [XLEN-1:0]          wb_data_i,
  input  logic                     trace_ready_i,
  output logic                     trace_valid_o,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [4:0]               trace_rd_o,
  output logic [XLEN-1:0]          trace_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [31:0]              cycles_o,
  output logic                     halted_o,
  output logic                     timeout_o,
  output logic                     done_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RLW = $clog2(HALT_REPEAT + 1);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [RLW-1:0] HALT_LEN  = RLW'(HALT_REPEAT);
  localparam logic [31:0]    LAST_CYC  = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_TIMEOUT} state_e;

  state_e          state_q,    state_d;
  logic [31:0]     cycles_q,   cycles_d;
  logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [AW:0]     count_q,    count_d;
  logic            overflow_q, overflow_d;
  logic            hist_q,     hist_d;
  logic [RLW-1:0]  run_len_q,  run_len_d;
  logic [XLEN-1:0] last_pc_q;

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic in_run, full, pop, capture, push;

  always_comb begin
    in_run  = (state_q == S_RUN);
    full    = (count_q == FULL_CNT);
    pop     = (count_q != '0) && trace_ready_i;
    capture = in_run && reg_write_i && (rd_i != 5'd0);
    // A full FIFO can still accept a capture when the head leaves the same edge.
    push    = capture && (!full || pop);

    state_d    = state_q;
    cycles_d   = cycles_q;
    overflow_d = overflow_q;
    hist_d     = hist_q;
    run_len_d  = run_len_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    if (capture && full && !pop) overflow_d = 1'b1;

    if (in_run) begin
      cycles_d  = cycles_q + 32'd1;
      hist_d    = 1'b1;
      // First sample after reset has no predecessor, so it starts a run of 1.
      run_len_d = (hist_q && (pc_i == last_pc_q)) ? run_len_q + 1'b1 : RLW'(1);
      // Halt wins over timeout when both land on the same edge.
      if (run_len_d == HALT_LEN)    state_d = S_HALTED;
      else if (cycles_q == LAST_CYC) state_d = S_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      state_q    <= S_RUN;
      cycles_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hist_q     <= 1'b0;
      run_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hist_q     <= hist_d;
      run_len_q  <= run_len_d;
    end
  end

  // Storage and PC history are not reset; hist_q and the pointers decide
  // whether their contents are meaningful.
  always_ff @(posedge clk) begin
    last_pc_q <= pc_i;
    if (push) begin
      mem_pc[wr_ptr_q]   <= pc_i;
      mem_rd[wr_ptr_q]   <= rd_i;
      mem_data[wr_ptr_q] <= wb_data_i;
    end
  end

  assign trace_valid_o = (count_q != '0);
  assign trace_pc_o    = mem_pc[rd_ptr_q];
  assign trace_rd_o    = mem_rd[rd_ptr_q];
  assign trace_data_o  = mem_data[rd_ptr_q];
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign cycles_o      = cycles_q;
  assign halted_o      = (state_q == S_HALTED);
  assign timeout_o     = (state_q == S_TIMEOUT);
  assign done_o        = (state_q != S_RUN);

endmodule

// File: tb/tb_exec_trace_monitor.sv
module tb_exec_trace_monitor;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic        start = 1'b0;
  logic [31:0] pc    = '0;
  logic        rw    = 1'b0;
  logic [4:0]  rd    = '0;
  logic [31:0] wb    = '0;
  logic        rdy   = 1'b0;
  logic        tvalid;
  logic [31:0] tpc, tdata;
  logic [4:0]  trd;
  logic [4:0]  count;
  logic        ovf, halted, tmo, done;
  logic [31:0] cyc;

  exec_trace_monitor dut (
    .clk(clk), .start(start), .pc_i(pc), .reg_write_i(rw), .rd_i(rd),
    .wb_data_i(wb), .trace_ready_i(rdy), .trace_valid_o(tvalid),
    .trace_pc_o(tpc), .trace_rd_o(trd), .trace_data_o(tdata),
    .count_o(count), .overflow_o(ovf), .cycles_o(cyc),
    .halted_o(halted), .timeout_o(tmo), .done_o(done)
  );

  // Timeout DUT (MAX_CYCLES = 10)
  logic        start_t = 1'b0;
  logic [31:0] pc_t    = '0;
  logic        rw_t    = 1'b0;
  logic [4:0]  rd_t    = '0;
  logic [31:0] wb_t    = '0;
  logic        rdy_t   = 1'b0;
  logic        tvalid_t;
  logic [31:0] tpc_t, tdata_t;
  logic [4:0]  trd_t;
  logic [4:0]  count_t;
  logic        ovf_t, halted_t, tmo_t, done_t;
  logic [31:0] cyc_t;

  exec_trace_monitor #(.MAX_CYCLES(10)) dut_t (
    .clk(clk), .start(start_t), .pc_i(pc_t), .reg_write_i(rw_t), .rd_i(rd_t),
    .wb_data_i(wb_t), .trace_ready_i(rdy_t), .trace_valid_o(tvalid_t),
    .trace_pc_o(tpc_t), .trace_rd_o(trd_t), .trace_data_o(tdata_t),
    .count_o(count_t), .overflow_o(ovf_t), .cycles_o(cyc_t),
    .halted_o(halted_t), .timeout_o(tmo_t), .done_o(done_t)
  );

  int   checks = 0;
  int   errors = 0;
  int   nsteps = 0;
  bit   pc_auto = 1'b1;
  ent_t exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
    nsteps++;
    if (pc_auto) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    start = 1'b0; rw = 1'b0; rdy = 1'b0;
    step(); step();
    start = 1'b1;
    nsteps = 0;
    exp_q.delete();
  endtask

  // Drive one write for one edge; the expected entry is queued when it
  // should land in the FIFO.
  task automatic wr(input logic [4:0] r, input logic [31:0] d, input bit cap);
    ent_t e;
    rw = 1'b1; rd = r; wb = d;
    if (cap) begin
      e.pc = pc; e.rd = r; e.d = d;
      exp_q.push_back(e);
    end
    step();
    rw = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    ent_t e;
    guard = 0;
    rw = 1'b0; rdy = 1'b1;
    while (exp_q.size() > 0 && guard < 64) begin
      e = exp_q[0];
      checks++;
      if (tvalid !== 1'b1) begin
        errors++;
        $display("FAIL %s valid: got %b, want 1 (%0d entries left)", tag, tvalid, exp_q.size());
        exp_q.delete();
      end else begin
        checks++;
        if ({tpc, trd, tdata} !== {e.pc, e.rd, e.d}) begin
          errors++;
          $display("FAIL %s entry: got pc=%h rd=%0d d=%h, want pc=%h rd=%0d d=%h",
                   tag, tpc, trd, tdata, e.pc, e.rd, e.d);
        end
        void'(exp_q.pop_front());
        step();
      end
      guard++;
    end
    rdy = 1'b0;
    checks++;
    if (tvalid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL %s empty: got valid=%b count=%0d, want 0/0", tag, tvalid, count);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; rw = 1'b1; rd = 5'd3; wb = 32'h1234; rdy = 1'b1;
    step(); step();
    checks++;
    if ({tvalid, count, ovf} !== 7'd0) begin
      errors++;
      $display("FAIL reset_fifo: got valid=%b count=%0d ovf=%b, want 0", tvalid, count, ovf);
    end
    checks++;
    if (cyc !== 32'd0) begin
      errors++;
      $display("FAIL reset_cycles: got %0d, want 0", cyc);
    end
    checks++;
    if ({halted, tmo, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b, want 000", {halted, tmo, done});
    end
    rw = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    pc_auto = 1'b1; pc = 32'h4;
    wr(5'd5, 32'h0A, 1'b1);
    wr(5'd6, 32'h14, 1'b1);
    wr(5'd0, 32'h99, 1'b0);
    checks++;
    if (count !== 5'd2) begin
      errors++;
      $display("FAIL basic_count: got %0d, want 2", count);
    end
    checks++;
    if (cyc !== 32'd3) begin
      errors++;
      $display("FAIL basic_cycles: got %0d, want 3", cyc);
    end
    drain("basic_drain");
    checks++;
    if (cyc !== nsteps) begin
      errors++;
      $display("FAIL basic_cycles_run: got %0d, want %0d", cyc, nsteps);
    end
  endtask

  task automatic test_overflow();
    ent_t e;
    do_reset();
    pc_auto = 1'b1; pc = 32'h1000;
    for (int i = 0; i < 16; i++) wr(5'(i + 1), 32'hA000 + i, 1'b1);
    checks++;
    if (count !== 5'd16 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d ovf=%b, want 16/0", count, ovf);
    end
    wr(5'd17, 32'hDEAD, 1'b0);
    checks++;
    if (count !== 5'd16 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got count=%0d ovf=%b, want 16/1", count, ovf);
    end
    drain("ovf_drain");
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, want 1", ovf);
    end

    // Full FIFO with a pop on the same edge accepts the new capture.
    do_reset();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset: got %b, want 0", ovf);
    end
    pc = 32'h2000;
    for (int i = 0; i < 16; i++) wr(5'(i + 10), 32'hB000 + i, 1'b1);
    e = exp_q[0];
    checks++;
    if (tvalid !== 1'b1 || {tpc, trd, tdata} !== {e.pc, e.rd, e.d}) begin
      errors++;
      $display("FAIL fullpop_head: got pc=%h rd=%0d d=%h, want pc=%h rd=%0d d=%h",
               tpc, trd, tdata, e.pc, e.rd, e.d);
    end
    void'(exp_q.pop_front());
    rdy = 1'b1;
    wr(5'd31, 32'hCAFE, 1'b1);
    rdy = 1'b0;
    checks++;
    if (count !== 5'd16 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL fullpop: got count=%0d ovf=%b, want 16/0", count, ovf);
    end
    drain("fullpop_drain");
  endtask

  task automatic test_empty_pushpop();
    do_reset();
    pc_auto = 1'b1; pc = 32'h300;
    rdy = 1'b1;
    wr(5'd4, 32'h44, 1'b1);
    rdy = 1'b0;
    checks++;
    if (count !== 5'd1 || tvalid !== 1'b1) begin
      errors++;
      $display("FAIL empty_pushpop: got count=%0d valid=%b, want 1/1", count, tvalid);
    end
    drain("empty_pushpop_drain");
  endtask

  task automatic test_halt();
    do_reset();
    pc_auto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h10 + 32'(4 * i);
      step();
    end
    pc = 32'h20;
    step(); step(); step();
    checks++;
    if (halted !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL halt_early: got halted=%b done=%b, want 0/0", halted, done);
    end
    wr(5'd7, 32'hABC, 1'b1);
    checks++;
    if ({halted, tmo, done} !== 3'b101) begin
      errors++;
      $display("FAIL halt_status: got %b, want 101", {halted, tmo, done});
    end
    checks++;
    if (cyc !== 32'd8 || count !== 5'd1) begin
      errors++;
      $display("FAIL halt_edge: got cyc=%0d count=%0d, want 8/1", cyc, count);
    end
    pc = 32'h24;
    wr(5'd8, 32'h111, 1'b0);
    wr(5'd9, 32'h222, 1'b0);
    checks++;
    if (cyc !== 32'd8 || count !== 5'd1 || halted !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL halt_absorb: got cyc=%0d count=%0d halted=%b ovf=%b, want 8/1/1/0",
               cyc, count, halted, ovf);
    end
    drain("halt_drain");
    pc_auto = 1'b1;
  endtask

  task automatic test_timeout();
    start_t = 1'b0;
    @(posedge clk); #1;
    start_t = 1'b1; pc_t = 32'h100;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1; pc_t = pc_t + 32'd4;
    end
    checks++;
    if (tmo_t !== 1'b0 || cyc_t !== 32'd9) begin
      errors++;
      $display("FAIL tmo_early: got tmo=%b cyc=%0d, want 0/9", tmo_t, cyc_t);
    end
    @(posedge clk); #1; pc_t = pc_t + 32'd4;
    checks++;
    if ({halted_t, tmo_t, done_t} !== 3'b011 || cyc_t !== 32'd10) begin
      errors++;
      $display("FAIL tmo_status: got hto=%b cyc=%0d, want 011/10", {halted_t, tmo_t, done_t}, cyc_t);
    end
    repeat (3) begin
      @(posedge clk); #1; pc_t = pc_t + 32'd4;
    end
    checks++;
    if (cyc_t !== 32'd10 || tmo_t !== 1'b1) begin
      errors++;
      $display("FAIL tmo_hold: got cyc=%0d tmo=%b, want 10/1", cyc_t, tmo_t);
    end

    // Halt run completes on the same edge as the timeout.
    start_t = 1'b0;
    @(posedge clk); #1;
    start_t = 1'b1; pc_t = 32'h200;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; pc_t = pc_t + 32'd4;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (halted_t !== 1'b0 || tmo_t !== 1'b0) begin
      errors++;
      $display("FAIL tie_early: got halted=%b tmo=%b, want 0/0", halted_t, tmo_t);
    end
    @(posedge clk); #1;
    checks++;
    if ({halted_t, tmo_t, done_t} !== 3'b101 || cyc_t !== 32'd10) begin
      errors++;
      $display("FAIL tie_status: got hto=%b cyc=%0d, want 101/10", {halted_t, tmo_t, done_t}, cyc_t);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    pc_auto = 1'b1; pc = 32'h400;
    for (int i = 0; i < 5; i++) wr(5'(i + 20), 32'hC000 + i, 1'b1);
    rdy = 1'b1;
    step();
    start = 1'b0; rw = 1'b1; rd = 5'd3; wb = 32'h77;
    step();
    start = 1'b1; rw = 1'b0; rdy = 1'b0;
    exp_q.delete();
    checks++;
    if (count !== 5'd0 || tvalid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fifo: got count=%0d valid=%b ovf=%b, want 0/0/0", count, tvalid, ovf);
    end
    checks++;
    if (cyc !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_status: got cyc=%0d done=%b, want 0/0", cyc, done);
    end
    wr(5'd9, 32'h55, 1'b1);
    checks++;
    if (count !== 5'd1 || cyc !== 32'd1) begin
      errors++;
      $display("FAIL midreset_resume: got count=%0d cyc=%0d, want 1/1", count, cyc);
    end
    drain("midreset_drain");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_pushpop();
    test_halt();
    test_timeout();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
